neuron_mac_seq: RTL
===================

Name: neuron_mac_seq

Overview:
Sequencer sitting directly upstream of the 32-bit ALU execution unit (ADD/MUL/SLT); evaluates one neuron: sum = bias + Σ(x_i·w_i), fire = (threshold < sum), signed.
- Drives the ALU's control and operand inputs and consumes its combinational result.
- Input pairs arrive over a valid/ready stream; the neuron result leaves over a valid/ready port.
- ALU is instantiated alongside it (not inside) so the datapath stays shared.

Parameters:
- nBits, 32, datapath/ALU width
- CNT_W, 8, width of input-pair count

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin neuron evaluation; sampled only in IDLE
- n_inputs  in  CNT_W  number of (x,w) pairs; captured on start
- bias  in  nBits  signed initial accumulator value; captured on start
- threshold  in  nBits  signed firing threshold; captured on start
- in_valid  in  1  (in_x,in_w) pair available
- in_ready  out  1  sequencer accepts pair this cycle
- in_x  in  nBits  signed input activation
- in_w  in  nBits  signed weight
- alu_ctrl  out  3  ALUControl to ALU (000 ADD, 001 MUL, 010 SLT)
- src_a  out  nBits  SrcA to ALU
- src_b  out  nBits  SrcB to ALU
- alu_result  in  nBits  ALUResult from ALU, combinational same cycle
- busy  out  1  high in every state except IDLE
- out_valid  out  1  result valid; held until out_ready
- out_ready  in  1  consumer accepts result
- out_sum  out  nBits  final accumulator
- out_fire  out  1  1 when threshold < sum (signed)

Behaviour:
- States: IDLE, WAIT_IN, MUL, ACC, THRESH, OUT.
- Reset (async, rst_n=0): state=IDLE; acc, prod, x_r, w_r, thr_r, cnt, out_sum = 0; out_fire=0; out_valid=0; in_ready=0; busy=0. Reset mid-operation aborts silently; no out_valid is produced.
- ALU drive is a combinational decode of the registered state and registers:
  - IDLE/WAIT_IN/OUT: ADD, 0, 0
  - MUL: MUL, x_r, w_r
  - ACC: ADD, acc, prod
  - THRESH: SLT, thr_r, acc
- IDLE:
  - On start: acc<=bias, thr_r<=threshold, cnt<=n_inputs.
  - n_inputs==0 -> THRESH; else -> WAIT_IN.
  - start outside IDLE is ignored.
- WAIT_IN: in_ready=1 (Moore, this state only). On in_valid: x_r<=in_x, w_r<=in_w -> MUL.
- MUL: prod<=alu_result (low nBits of product, truncation is the ALU's) -> ACC.
- ACC:
  - acc<=alu_result (wraps modulo 2^nBits, no saturation); cnt<=cnt-1.
  - cnt==1 -> THRESH; else -> WAIT_IN.
- THRESH: out_fire<=alu_result[0]; out_sum<=acc -> OUT.
- OUT: out_valid=1; out_sum/out_fire stable. On out_ready -> IDLE (out_valid low next cycle). start in the same cycle is ignored.
- Latency:
  - Per pair: 3 cycles minimum (accept, MUL, ACC).
  - Overall: out_valid rises 3·N+2 cycles after the start edge when in_valid is held high (N = n_inputs). For N=0 it rises 2 cycles after start.
- in_valid stalls extend WAIT_IN indefinitely without side effects.

Decomposition:
- Shared package nn_alu_pkg:
  - ALU op constants ALU_ADD=3'b000, ALU_MUL=3'b001, ALU_SLT=3'b010
  - default nBits
  - state enum typedef for this block
- The ALU must import the same op constants.
- No sub-module: counter and FSM are inline. The ALU is instantiated in the enclosing neuron tile, wired to alu_ctrl/src_a/src_b/alu_result.

Test Plan:
- Basic: bias=0, thr=1, N=2, pairs (2,3),(4,-1) -> out_sum=2, out_fire=1; in_valid held high gives out_valid 8 cycles after start.
- Zero inputs: N=0, bias=-5, thr=-6 -> out_sum=-5 (0xFFFFFFFB), out_fire=1 (-6<-5), 2 cycles after start; in_ready never asserts.
- Non-fire and equality: bias=7, N=1, pair (0,9), thr=7 -> out_sum=7, out_fire=0 (7<7 false).
- Wrap: N=2, pairs (0x10000,0x10000),(0x7FFFFFFF,1), bias=1 -> product 0, then out_sum=0x80000000, thr=0 -> out_fire=0 (signed negative).
- Handshakes:
  - in_valid gaps of 5 cycles between pairs -> same result as the basic case, with the 3-cycle per-pair timing after each accept.
  - out_ready held low 10 cycles -> out_valid/out_sum stable throughout.
  - start pulsed while busy -> ignored.
- Reset mid-run: rst_n low during ACC of pair 2 -> all outputs 0 immediately (async). A new start afterwards produces a correct, independent result.

Source files
------------

// File: rtl/nn_alu_pkg.sv
// Shared definitions for the neuron tile: ALU op encodings used by both the
// ALU and the MAC sequencer, the default datapath width, and the sequencer
// state encoding.
package nn_alu_pkg;

  localparam int NBITS_DEF = 32;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_MUL = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b010;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_IN,
    S_MUL,
    S_ACC,
    S_THRESH,
    S_OUT
  } nmac_state_e;

endpackage

// File: rtl/nn_alu.sv
// Shared 32-bit ALU of the neuron tile (ADD / MUL / SLT), purely combinational.
// Ports:
//   alu_ctrl   - op select (ALU_ADD, ALU_MUL, ALU_SLT)
//   src_a      - operand A
//   src_b      - operand B
//   alu_result - ADD: a+b, MUL: low nBits of a*b, SLT: signed a<b in bit 0
module nn_alu
  import nn_alu_pkg::*;
#(
  parameter int nBits = NBITS_DEF
) (
  input  logic [2:0]       alu_ctrl,
  input  logic [nBits-1:0] src_a,
  input  logic [nBits-1:0] src_b,
  output logic [nBits-1:0] alu_result
);

  always_comb begin
    alu_result = '0;
    unique case (alu_ctrl)
      ALU_ADD: alu_result = src_a + src_b;
      ALU_MUL: alu_result = src_a * src_b;  // truncated to nBits
      ALU_SLT: alu_result = {{(nBits-1){1'b0}}, $signed(src_a) < $signed(src_b)};
      default: alu_result = '0;
    endcase
  end

endmodule

// File: rtl/neuron_mac_seq.sv
// Neuron MAC sequencer. Evaluates sum = bias + sum(x_i*w_i) and
// fire = (threshold < sum), signed, by driving the shared ALU one op per cycle.
// Ports:
//   clk, rst_n            - clock, async active-low reset
//   start                 - begin evaluation (sampled in IDLE only)
//   n_inputs/bias/threshold - job parameters, captured on start
//   in_valid/in_ready/in_x/in_w - (x,w) pair stream
//   alu_ctrl/src_a/src_b  - ALU drive (decoded from state)
//   alu_result            - ALU result, combinational same cycle
//   busy                  - high outside IDLE
//   out_valid/out_ready/out_sum/out_fire - result port
module neuron_mac_seq
  import nn_alu_pkg::*;
#(
  parameter int nBits = NBITS_DEF,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] n_inputs,
  input  logic [nBits-1:0] bias,
  input  logic [nBits-1:0] threshold,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [nBits-1:0] in_x,
  input  logic [nBits-1:0] in_w,
  output logic [2:0]       alu_ctrl,
  output logic [nBits-1:0] src_a,
  output logic [nBits-1:0] src_b,
  input  logic [nBits-1:0] alu_result,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [nBits-1:0] out_sum,
  output logic             out_fire
);

  nmac_state_e      state;
  logic [nBits-1:0] acc, prod, x_r, w_r, thr_r;
  logic [CNT_W-1:0] cnt;

  // Moore flags: pure decodes of the state register, so they are 0 in reset.
  assign in_ready  = (state == S_WAIT_IN);
  assign busy      = (state != S_IDLE);
  assign out_valid = (state == S_OUT);

  // ALU drive. Idle states present ADD 0,0 so the shared ALU sees quiet operands.
  always_comb begin
    alu_ctrl = ALU_ADD;
    src_a    = '0;
    src_b    = '0;
    unique case (state)
      S_MUL: begin
        alu_ctrl = ALU_MUL;
        src_a    = x_r;
        src_b    = w_r;
      end
      S_ACC: begin
        alu_ctrl = ALU_ADD;
        src_a    = acc;
        src_b    = prod;
      end
      S_THRESH: begin
        alu_ctrl = ALU_SLT;
        src_a    = thr_r;
        src_b    = acc;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      acc      <= '0;
      prod     <= '0;
      x_r      <= '0;
      w_r      <= '0;
      thr_r    <= '0;
      cnt      <= '0;
      out_sum  <= '0;
      out_fire <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            acc   <= bias;
            thr_r <= threshold;
            cnt   <= n_inputs;
            state <= (n_inputs == '0) ? S_THRESH : S_WAIT_IN;
          end
        end
        S_WAIT_IN: begin
          if (in_valid) begin
            x_r   <= in_x;
            w_r   <= in_w;
            state <= S_MUL;
          end
        end
        S_MUL: begin
          prod  <= alu_result;
          state <= S_ACC;
        end
        S_ACC: begin
          acc   <= alu_result;  // wraps, no saturation
          cnt   <= cnt - 1'b1;
          state <= (cnt == CNT_W'(1)) ? S_THRESH : S_WAIT_IN;
        end
        S_THRESH: begin
          out_fire <= alu_result[0];
          out_sum  <= acc;
          state    <= S_OUT;
        end
        S_OUT: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
